// File: rtl/kernel_cmd_sequencer.sv
// Kernel command sequencer: decodes host commands from the AXI-lite command
// register, drives the engine start/abort handshake, latches launch arguments,
// times each run with a watchdog and assembles the status words for readback.
module kernel_cmd_sequencer #(
    parameter int          AXI_LITE_ARG_NUM    = 32,
    parameter int          AXI_LITE_WORD_WIDTH = 32,
    parameter int          LAUNCH_ARGS         = 4,
    parameter logic [31:0] TIMEOUT_CYCLES      = 32'd1000000
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     kernel_command,
    input  logic                           kernel_command_new,
    input  logic [AXI_LITE_WORD_WIDTH-1:0] kernel_engine_arg [AXI_LITE_ARG_NUM],
    input  logic                           engine_idle,
    input  logic                           engine_done,
    output logic                           engine_start,
    output logic                           engine_abort,
    output logic [AXI_LITE_WORD_WIDTH-1:0] engine_arg [LAUNCH_ARGS],
    output logic [AXI_LITE_WORD_WIDTH-1:0] kernel_engine_status [AXI_LITE_ARG_NUM],
    output logic                           counter_reset,
    output logic                           counter_start
);

    localparam int W = AXI_LITE_WORD_WIDTH;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_RUN    = 2'd2;
    localparam logic [1:0] ST_ABORT  = 2'd3;

    localparam logic [7:0] OP_START   = 8'h01;
    localparam logic [7:0] OP_ABORT   = 8'h02;
    localparam logic [7:0] OP_CLEAR   = 8'h03;
    localparam logic [7:0] OP_CNT_RST = 8'h04;

    localparam logic [7:0] ERR_ILLEGAL = 8'h01;
    localparam logic [7:0] ERR_BUSY    = 8'h02;
    localparam logic [7:0] ERR_TIMEOUT = 8'h03;

    // Last live-count value of a run before the watchdog fires.
    localparam logic [W-1:0] TIMEOUT_LAST = W'(TIMEOUT_CYCLES - 32'd1);

    logic [1:0]   state;
    logic [1:0]   state_next;
    logic [W-1:0] live_cnt;
    logic [W-1:0] last_run;
    logic [W-1:0] launch_cnt;
    logic         done_sticky;
    logic         aborted_sticky;
    logic         error_sticky;
    logic [15:0]  err_word;

    logic         cmd_start;
    logic         cmd_abort;
    logic         cmd_clear;
    logic         cmd_cnt_rst;
    logic         cmd_illegal;
    logic         in_idle;
    logic         wd_hit;
    logic         err_load;
    logic [7:0]   err_code;
    logic [7:0]   err_opcode;

    assign in_idle       = (state == ST_IDLE);
    assign engine_start  = (state == ST_LAUNCH);
    assign engine_abort  = (state == ST_ABORT);
    assign counter_start = (state == ST_LAUNCH) || (state == ST_RUN);

    // Command decode, next-state selection and error classification.
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        cmd_start   = kernel_command_new && (kernel_command == OP_START);
        cmd_abort   = kernel_command_new && (kernel_command == OP_ABORT);
        cmd_clear   = kernel_command_new && (kernel_command == OP_CLEAR);
        cmd_cnt_rst = kernel_command_new && (kernel_command == OP_CNT_RST);
        cmd_illegal = kernel_command_new && (kernel_command > OP_CNT_RST);
        wd_hit      = (TIMEOUT_CYCLES != 32'd0) && (live_cnt == TIMEOUT_LAST);

        state_next = state;
        case (state)
            ST_IDLE:   if (cmd_start) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = cmd_abort ? ST_ABORT : ST_RUN;
            // Completion wins over both the watchdog and a same-cycle abort.
            ST_RUN: begin
                if (engine_done)              state_next = ST_IDLE;
                else if (cmd_abort || wd_hit) state_next = ST_ABORT;
            end
            default:   if (engine_idle) state_next = ST_IDLE;
        endcase

        err_load   = 1'b0;
        err_code   = 8'h00;
        err_opcode = kernel_command;
        if (cmd_illegal) begin
            err_load = 1'b1;
            err_code = ERR_ILLEGAL;
        end else if (!in_idle && (cmd_start || cmd_clear || cmd_cnt_rst)) begin
            err_load = 1'b1;
            err_code = ERR_BUSY;
        end
        // A watchdog expiry is reported against the START that began the run.
        if ((state == ST_RUN) && !engine_done && wd_hit) begin
            err_load   = 1'b1;
            err_code   = ERR_TIMEOUT;
            err_opcode = OP_START;
        end
    end

    // Sequencer state register.
    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Capture the launch arguments (host words 1..LAUNCH_ARGS) on START.
    // NOTE: this small argument bank is reset because every output must read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LAUNCH_ARGS; i++) engine_arg[i] <= '0;
        end else if (in_idle && cmd_start) begin
            for (int i = 0; i < LAUNCH_ARGS; i++) engine_arg[i] <= kernel_engine_arg[i+1];
        end
    end

    // Run timing, launch counting and the inner counter reset pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_cnt      <= '0;
            last_run      <= '0;
            launch_cnt    <= '0;
            counter_reset <= 1'b0;
        end else begin
            counter_reset <= in_idle && cmd_cnt_rst;
            if (in_idle && (cmd_start || cmd_cnt_rst)) begin
                live_cnt <= '0;
            end else if ((state == ST_RUN) && (live_cnt != '1)) begin
                live_cnt <= live_cnt + 1'b1;
            end
            if ((state == ST_RUN) && engine_done) last_run <= live_cnt;
            if (state == ST_LAUNCH) launch_cnt <= launch_cnt + 1'b1;
        end
    end

    // Sticky completion/abort/error flags and the last-error word.
    always_ff @(posedge clk) begin
        if (rst) begin
            done_sticky    <= 1'b0;
            aborted_sticky <= 1'b0;
            error_sticky   <= 1'b0;
            err_word       <= '0;
        end else begin
            if (in_idle && cmd_clear) begin
                done_sticky    <= 1'b0;
                aborted_sticky <= 1'b0;
                error_sticky   <= 1'b0;
                err_word       <= '0;
            end
            if ((state == ST_RUN) && engine_done)    done_sticky    <= 1'b1;
            if ((state == ST_ABORT) && engine_idle) aborted_sticky <= 1'b1;
            if (err_load) begin
                error_sticky <= 1'b1;
                err_word     <= {err_opcode, err_code};
            end
        end
    end

    // Status word map presented to the AXI-lite slave; unlisted words read 0.
    always_comb begin
        for (int i = 0; i < AXI_LITE_ARG_NUM; i++) kernel_engine_status[i] = '0;
        kernel_engine_status[0][1:0] = state;
        kernel_engine_status[0][8]   = done_sticky;
        kernel_engine_status[0][9]   = aborted_sticky;
        kernel_engine_status[0][10]  = error_sticky;
        kernel_engine_status[0][11]  = !in_idle;
        kernel_engine_status[1]      = last_run;
        kernel_engine_status[2]      = live_cnt;
        kernel_engine_status[3]      = launch_cnt;
        kernel_engine_status[4]      = W'(err_word);
    end

endmodule

// File: doc/kernel_cmd_sequencer.md
Name: kernel_cmd_sequencer

Overview:
Sequences the kernel engine from the host-written AXI-lite command register. It consumes kernel_command and kernel_command_new, then drives the engine start and abort handshake. It latches launch arguments, measures run cycles with a watchdog, and produces the kernel_engine_status words the AXI-lite slave returns on reads. It sits between the AXI-lite register interface and the engine datapath, and also drives the inner counter controls.

Parameters:
AXI_LITE_ARG_NUM, 32, number of status/argument words
AXI_LITE_WORD_WIDTH, 32, word width in bits
LAUNCH_ARGS, 4, number of argument words (kernel_engine_arg[1..LAUNCH_ARGS]) latched at launch
TIMEOUT_CYCLES, 32'd1000000, RUN watchdog limit; 0 disables the watchdog

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
kernel_command  in  8  opcode, valid when kernel_command_new=1
kernel_command_new  in  1  1-cycle pulse: new command written
kernel_engine_arg  in  ARG_NUM x WORD_W  host argument registers
engine_idle  in  1  engine quiescent (state_idle_pin)
engine_done  in  1  1-cycle completion pulse from engine
engine_start  out  1  1-cycle launch pulse
engine_abort  out  1  level; held high while aborting
engine_arg  out  LAUNCH_ARGS x WORD_W  arguments latched at launch
kernel_engine_status  out  ARG_NUM x WORD_W  status words to AXI-lite slave
counter_reset  out  1  1-cycle inner counter reset pulse
counter_start  out  1  level; high while the engine is launched or running

Behaviour:
- All logic is synchronous to clk. Reset is synchronous active-high.
- Reset values: state=IDLE; every output 0; all status words, counters and sticky bits 0.
- Reset mid-run takes effect immediately. engine_abort is not asserted on reset.
- Opcodes:
  - 0x00 NOP
  - 0x01 START
  - 0x02 ABORT
  - 0x03 CLEAR (clears sticky bits and the error word)
  - 0x04 CNT_RST
  - Any other value is ILLEGAL.
- Commands are sampled only in a cycle where kernel_command_new=1.
- FSM states (encoding): IDLE=0, LAUNCH=1, RUN=2, ABORT=3.
- IDLE:
  - START: latch engine_arg[i] = kernel_engine_arg[i+1]; zero the live cycle counter; go to LAUNCH.
  - CLEAR: clear sticky bits and status[4].
  - CNT_RST: pulse counter_reset for 1 cycle; zero the live cycle counter.
  - NOP: no action.
- LAUNCH (exactly 1 cycle):
  - engine_start=1 and counter_start=1; increment the launch count (wraps).
  - Next state is RUN. If ABORT arrives in this cycle, the next state is ABORT instead.
- RUN:
  - counter_start=1; the live cycle counter increments each cycle, saturating at all-ones.
  - engine_done=1: status[1] <= live count; set done sticky; go to IDLE.
  - ABORT command: go to ABORT.
  - Watchdog: TIMEOUT_CYCLES!=0 and live count == TIMEOUT_CYCLES-1 -> go to ABORT, error code 0x3.
- ABORT:
  - engine_abort=1, counter_start=0; engine_done is ignored.
  - On engine_idle=1: set aborted sticky; go to IDLE. engine_abort deasserts in the IDLE cycle.
- Error codes:
  - ILLEGAL in any state -> 0x1.
  - START, CLEAR or CNT_RST while not IDLE -> 0x2 (BUSY); the command is discarded.
  - ABORT in IDLE is ignored, no error.
  - Every error sets the error sticky and loads status[4] = {opcode[15:8], code[7:0]}. The latest error overwrites.
- Simultaneous events in RUN:
  - engine_done beats the watchdog.
  - engine_done beats an ABORT command; that ABORT is discarded with no error.
- Status map (unlisted words and bits read 0):
  - status[0]: [1:0] state, [8] done, [9] aborted, [10] error, [11] busy (state != IDLE).
  - status[1]: last run cycles.
  - status[2]: live cycle counter.
  - status[3]: launch count.
  - status[4]: last error.
- Latency: command seen in cycle N -> state/status updated in N+1 -> engine_start high in N+1.

Test Plan:
- After reset, cmd 0x01 with arg[1]=0xA5A5_0001 -> engine_start high exactly 1 cycle, engine_arg[0]=0xA5A5_0001, status[0][1:0]=2; engine_done after 10 RUN cycles -> status[1]=10, status[0]=0x100, status[3]=1.
- In RUN, cmd 0x02 -> engine_abort=1 until engine_idle rises 5 cycles later -> IDLE, status[0][9]=1; engine_done pulsed during ABORT is ignored.
- TIMEOUT_CYCLES=16, engine never done -> ABORT after 16 RUN cycles, status[4]=0x0103, error and aborted bits both set.
- In RUN, cmd 0x01 -> status[4]=0x0102, no second engine_start; then cmd 0x7F -> status[4]=0x7F01; after IDLE, cmd 0x03 -> status[0][10:8]=0, status[4]=0.
- In RUN, engine_done and cmd 0x02 in the same cycle -> IDLE, done=1, aborted=0, no error.
- rst asserted mid-RUN for 1 cycle -> next cycle all outputs 0, status all 0, state IDLE; cmd 0x04 -> counter_reset 1-cycle pulse.
